// File: rtl/nib_serial_addsub_pkg.sv
// nib_serial_addsub_pkg: shared state type, nibble width and counter sizing helper
package nib_serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int NIB = 4;
  function automatic int cnt_w(input int width);
    return (width / NIB) <= 2 ? 1 : $clog2(width / NIB);
  endfunction
endpackage

// File: rtl/nib_serial_addsub_add4_cla.sv
// add4_cla: combinational 4-bit carry-lookahead slice; in a, b, c_in; out sum, c_out, group p/g
module add4_cla
  import nib_serial_addsub_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           c_in,
  output logic [NIB-1:0] sum,
  output logic           c_out,
  output logic           grp_p,
  output logic           grp_g
);
  logic [NIB-1:0] p, g, c;
  assign p = a ^ b;
  assign g = a & b;
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign c_out = grp_g | (grp_p & c_in);
  assign sum = p ^ c;
endmodule

// File: rtl/nib_serial_addsub.sv
// nib_serial_addsub: nibble-serial add/sub; in clk rst_n in_valid a b sub out_ready; out in_ready out_valid sum c_out ovf zero
module nib_serial_addsub
  import nib_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int NN = WIDTH / NIB;
  localparam int CW = cnt_w(WIDTH);
  state_t         state;
  logic [WIDTH-1:0] a_r, b_r, sum_nx;
  logic [CW-1:0]  cnt;
  logic           carry, last;
  logic [NIB-1:0] s_sum;
  logic           s_cout, grp_p, grp_g, unused_pg;
  add4_cla u_cla (
    .a(a_r[cnt*NIB +: NIB]),
    .b(b_r[cnt*NIB +: NIB]),
    .c_in(carry),
    .sum(s_sum),
    .c_out(s_cout),
    .grp_p(grp_p),
    .grp_g(grp_g)
  );
  assign unused_pg = grp_p ^ grp_g;
  assign last = cnt == CW'(NN - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    sum_nx = sum;
    sum_nx[cnt*NIB +: NIB] = s_sum;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      cnt <= '0;
      carry <= 1'b0;
      sum <= '0;
      c_out <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_r <= a;
        b_r <= b ^ {WIDTH{sub}};
        carry <= sub;
        cnt <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      sum <= sum_nx;
      carry <= s_cout;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        c_out <= s_cout;
        ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_nx[WIDTH-1] != a_r[WIDTH-1]);
        zero <= ~|sum_nx;
        state <= DONE;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
endmodule
